// File: rtl/inv_sub_bytes_iter_if.sv
// Handshake bundle for the iterative InvSubBytes stage: upstream block intake,
// downstream result delivery and the busy indication.
interface inv_sub_bytes_iter_if;
    logic         in_valid;
    logic         in_ready;
    logic [127:0] in_state;
    logic         out_valid;
    logic         out_ready;
    logic [127:0] out_state;
    logic         busy;

    modport slave (
        input  in_valid, in_state, out_ready,
        output in_ready, out_valid, out_state, busy
    );

    modport master (
        output in_valid, in_state, out_ready,
        input  in_ready, out_valid, out_state, busy
    );
endinterface

// File: rtl/inv_sub_bytes_iter.sv
// Iterative AES InvSubBytes: substitutes LANES bytes of a 128-bit block per cycle
// through the inverse S-box, then presents the block on a valid/ready output.
module inv_sub_bytes_iter #(
    parameter int LANES = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    inv_sub_bytes_iter_if.slave  bus
);
    localparam int G  = 16 / LANES;
    localparam int GW = (G > 1) ? $clog2(G) : 1;
    localparam logic [GW-1:0] LAST_GRP = GW'(G - 1);

    // Inverse S-box, entry 0x00 in the top byte, one 16-entry row per line.
    localparam logic [2047:0] INV_SBOX_TBL = {
        128'h52096ad53036a538bf40a39e81f3d7fb,
        128'h7ce339829b2fff87348e4344c4dee9cb,
        128'h547b9432a6c2233dee4c950b42fac34e,
        128'h082ea16628d924b2765ba2496d8bd125,
        128'h72f8f66486689816d4a45ccc5d65b692,
        128'h6c704850fdedb9da5e154657a78d9d84,
        128'h90d8ab008cbcd30af7e45805b8b34506,
        128'hd02c1e8fca3f0f02c1afbd0301138a6b,
        128'h3a9111414f67dcea97f2cfcef0b4e673,
        128'h96ac7422e7ad3585e2f937e81c75df6e,
        128'h47f11a711d29c5896fb7620eaa18be1b,
        128'hfc563e4bc6d279209adbc0fe78cd5af4,
        128'h1fdda8338807c731b11210592780ec5f,
        128'h60517fa919b54a0d2de57a9f93c99cef,
        128'ha0e03b4dae2af5b0c8ebbb3c83539961,
        128'h172b047eba77d626e169146355210c7d
    };

    if (!(LANES == 1 || LANES == 2 || LANES == 4 || LANES == 8 || LANES == 16)) begin : g_lanes_check
        $error("inv_sub_bytes_iter: LANES must be 1, 2, 4, 8 or 16");
    end

    function automatic logic [7:0] inv_sbox(input logic [7:0] b);
        return INV_SBOX_TBL[2047 - 8*int'(b) -: 8];
    endfunction

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_e;

    state_e          state_q, state_d;
    logic [GW-1:0]   grp_q, grp_d;
    logic [127:0]    work_q, work_d;
    logic [127:0]    sub_work;

    // Only the current group's LANES bytes pass through S-box lookups; the rest hold.
    always_comb begin
        sub_work = work_q;
        for (int l = 0; l < LANES; l++) begin
            sub_work[127 - 8*(int'(grp_q)*LANES + l) -: 8] =
                inv_sbox(work_q[127 - 8*(int'(grp_q)*LANES + l) -: 8]);
        end
    end

    always_comb begin
        state_d = state_q;
        grp_d   = grp_q;
        work_d  = work_q;
        unique case (state_q)
            IDLE: begin
                if (bus.in_valid) begin
                    work_d  = bus.in_state;
                    grp_d   = '0;
                    state_d = RUN;
                end
            end
            RUN: begin
                work_d = sub_work;
                if (grp_q == LAST_GRP) begin
                    grp_d   = '0;
                    state_d = DONE;
                end else begin
                    grp_d = grp_q + 1'b1;
                end
            end
            DONE: begin
                if (bus.out_ready) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
                grp_d   = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            grp_q   <= '0;
            work_q  <= '0;
        end else begin
            state_q <= state_d;
            grp_q   <= grp_d;
            work_q  <= work_d;
        end
    end

    assign bus.in_ready  = (state_q == IDLE);
    assign bus.out_valid = (state_q == DONE);
    assign bus.busy      = (state_q == RUN) || (state_q == DONE);
    assign bus.out_state = work_q;
endmodule

// File: tb/tb_inv_sub_bytes_iter.sv
// Self-checking bench for inv_sub_bytes_iter: LANES=4 handshake scenarios plus
// exhaustive byte coverage on LANES=1 and LANES=16 instances.
module tb_inv_sub_bytes_iter;
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    inv_sub_bytes_iter_if b4();
    inv_sub_bytes_iter_if b1();
    inv_sub_bytes_iter_if b16();

    inv_sub_bytes_iter #(.LANES(4))  dut4  (.clk(clk), .rst(rst), .bus(b4));
    inv_sub_bytes_iter #(.LANES(1))  dut1  (.clk(clk), .rst(rst), .bus(b1));
    inv_sub_bytes_iter #(.LANES(16)) dut16 (.clk(clk), .rst(rst), .bus(b16));

    // The LANES=1 and LANES=16 instances share stimulus; outputs are selected.
    logic         ex_sel16, ex_in_valid, ex_out_ready;
    logic [127:0] ex_in_state;
    assign b1.in_valid   = ex_in_valid;
    assign b1.in_state   = ex_in_state;
    assign b1.out_ready  = ex_out_ready;
    assign b16.in_valid  = ex_in_valid;
    assign b16.in_state  = ex_in_state;
    assign b16.out_ready = ex_out_ready;
    wire         ex_in_ready  = ex_sel16 ? b16.in_ready  : b1.in_ready;
    wire         ex_out_valid = ex_sel16 ? b16.out_valid : b1.out_valid;
    wire [127:0] ex_out_state = ex_sel16 ? b16.out_state : b1.out_state;

    int n_cmp = 0;
    int n_bad = 0;
    logic [127:0] exp_q[$];

    // Reference model: inverse affine transform followed by GF(2^8) inversion.
    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p, x, y;
        p = 8'h00; x = a; y = b;
        for (int i = 0; i < 8; i++) begin
            if (y[0]) p = p ^ x;
            x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
            y = {1'b0, y[7:1]};
        end
        return p;
    endfunction

    function automatic logic [7:0] ginv(input logic [7:0] a);
        if (a == 8'h00) return 8'h00;
        for (int c = 1; c < 256; c++) begin
            if (gmul(a, 8'(c)) == 8'h01) return 8'(c);
        end
        return 8'h00;
    endfunction

    function automatic logic [7:0] ref_byte(input logic [7:0] x);
        logic [7:0] y;
        y = {x[6:0], x[7]} ^ {x[4:0], x[7:5]} ^ {x[1:0], x[7:2]} ^ 8'h05;
        return ginv(y);
    endfunction

    function automatic logic [127:0] ref_block(input logic [127:0] s);
        logic [127:0] r;
        for (int i = 0; i < 16; i++) r[127 - 8*i -: 8] = ref_byte(s[127 - 8*i -: 8]);
        return r;
    endfunction

    task automatic cyc();
        @(negedge clk);
    endtask

    task automatic accept4(input logic [127:0] blk, output bit ok);
        int w;
        w = 0;
        while (!b4.in_ready && w < 40) begin cyc(); w++; end
        ok = b4.in_ready;
        if (ok) begin
            b4.in_valid = 1'b1;
            b4.in_state = blk;
            exp_q.push_back(ref_block(blk));
            cyc();
            b4.in_valid = 1'b0;
        end
    endtask

    task automatic wait_out4(input int limit, output int lat, output bit ok);
        lat = 0; ok = 1'b0;
        while (lat < limit && !ok) begin cyc(); lat++; ok = b4.out_valid; end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        cyc(); cyc();
        n_cmp++; if (b4.in_ready !== 1'b1) begin n_bad++; $display("FAIL rst_in_ready: got %b want 1", b4.in_ready); end
        n_cmp++; if (b4.out_valid !== 1'b0) begin n_bad++; $display("FAIL rst_out_valid: got %b want 0", b4.out_valid); end
        n_cmp++; if (b4.busy !== 1'b0) begin n_bad++; $display("FAIL rst_busy: got %b want 0", b4.busy); end
        n_cmp++; if (b4.out_state !== 128'h0) begin n_bad++; $display("FAIL rst_out_state: got %h want 0", b4.out_state); end
        n_cmp++; if ({b1.in_ready, b16.in_ready} !== 2'b11) begin n_bad++; $display("FAIL rst_ex_ready: got %b want 11", {b1.in_ready, b16.in_ready}); end
        rst = 1'b0;
        cyc();
    endtask

    task automatic test_single();
        bit ok; int lat; logic [127:0] e;
        b4.out_ready = 1'b1;
        accept4(128'h000102030405060708090a0b0c0d0e0f, ok);
        n_cmp++; if (!ok) begin n_bad++; $display("FAIL single_accept: in_ready never high"); end
        n_cmp++; if ({b4.in_ready, b4.busy} !== 2'b01) begin n_bad++; $display("FAIL single_run_ctrl: got %b want 01", {b4.in_ready, b4.busy}); end
        wait_out4(20, lat, ok);
        n_cmp++; if (!ok || lat != 4) begin n_bad++; $display("FAIL single_latency: got %0d (valid=%b) want 4", lat, ok); end
        e = (exp_q.size() > 0) ? exp_q.pop_front() : 128'hx;
        n_cmp++; if (b4.out_state !== e) begin n_bad++; $display("FAIL single_data: got %h want %h", b4.out_state, e); end
        n_cmp++; if (b4.out_state !== 128'h52096ad53036a538bf40a39e81f3d7fb) begin n_bad++; $display("FAIL single_const: got %h want 52096ad53036a538bf40a39e81f3d7fb", b4.out_state); end
        cyc();
        n_cmp++; if ({b4.in_ready, b4.out_valid, b4.busy} !== 3'b100) begin n_bad++; $display("FAIL single_idle: got %b want 100", {b4.in_ready, b4.out_valid, b4.busy}); end
    endtask

    task automatic test_back_to_back();
        int nacc, ngot; int acc[2]; bit take; logic [127:0] e;
        nacc = 0; ngot = 0; acc[0] = 0; acc[1] = 0;
        b4.out_ready = 1'b1;
        b4.in_valid  = 1'b1;
        b4.in_state  = {16{8'h63}};
        for (int ed = 0; ed < 60 && ngot < 2; ed++) begin
            take = b4.in_ready && b4.in_valid;
            if (take) begin
                exp_q.push_back(ref_block(b4.in_state));
                if (nacc < 2) acc[nacc] = ed;
                nacc++;
            end
            if (b4.out_valid && b4.out_ready) begin
                e = (exp_q.size() > 0) ? exp_q.pop_front() : 128'hx;
                n_cmp++; if (b4.out_state !== e) begin n_bad++; $display("FAIL b2b_data%0d: got %h want %h", ngot, b4.out_state, e); end
                n_cmp++; if (b4.out_state !== ((ngot == 0) ? {16{8'h00}} : {16{8'h52}})) begin n_bad++; $display("FAIL b2b_const%0d: got %h", ngot, b4.out_state); end
                ngot++;
            end
            cyc();
            if (take) begin
                if (nacc == 1) b4.in_state = {16{8'h00}};
                else b4.in_valid = 1'b0;
            end
        end
        b4.in_valid = 1'b0;
        n_cmp++; if (ngot != 2) begin n_bad++; $display("FAIL b2b_results: got %0d want 2", ngot); end
        n_cmp++; if (nacc != 2 || acc[1] - acc[0] != 6) begin n_bad++; $display("FAIL b2b_interval: got %0d accepts, gap %0d want 2 accepts gap 6", nacc, acc[1] - acc[0]); end
    endtask

    task automatic test_backpressure();
        bit ok; int lat; logic [127:0] e;
        b4.out_ready = 1'b0;
        accept4({$urandom(), $urandom(), $urandom(), $urandom()}, ok);
        wait_out4(20, lat, ok);
        n_cmp++; if (!ok) begin n_bad++; $display("FAIL bp_valid: out_valid not seen within %0d cycles", lat); end
        e = (exp_q.size() > 0) ? exp_q[0] : 128'hx;
        for (int i = 0; i < 10; i++) begin
            b4.in_valid = i[0];
            b4.in_state = {$urandom(), $urandom(), $urandom(), $urandom()};
            cyc();
            n_cmp++; if (b4.out_state !== e) begin n_bad++; $display("FAIL bp_state%0d: got %h want %h", i, b4.out_state, e); end
            n_cmp++; if ({b4.out_valid, b4.in_ready, b4.busy} !== 3'b101) begin n_bad++; $display("FAIL bp_ctrl%0d: got %b want 101", i, {b4.out_valid, b4.in_ready, b4.busy}); end
        end
        b4.in_valid  = 1'b0;
        b4.out_ready = 1'b1;
        e = (exp_q.size() > 0) ? exp_q.pop_front() : 128'hx;
        n_cmp++; if (b4.out_state !== e || b4.out_valid !== 1'b1) begin n_bad++; $display("FAIL bp_release: got %h valid %b want %h", b4.out_state, b4.out_valid, e); end
        cyc();
        n_cmp++; if ({b4.out_valid, b4.in_ready, b4.busy} !== 3'b010) begin n_bad++; $display("FAIL bp_idle: got %b want 010", {b4.out_valid, b4.in_ready, b4.busy}); end
        cyc();
        n_cmp++; if ({b4.out_valid, b4.in_ready, b4.busy} !== 3'b010) begin n_bad++; $display("FAIL bp_single_xfer: got %b want 010", {b4.out_valid, b4.in_ready, b4.busy}); end
    endtask

    task automatic test_reset_mid();
        bit ok, seen; int lat; logic [127:0] e;
        b4.out_ready = 1'b1;
        accept4({$urandom(), $urandom(), $urandom(), $urandom()}, ok);
        cyc();
        rst = 1'b1;
        cyc();
        rst = 1'b0;
        exp_q.delete();
        n_cmp++; if ({b4.out_valid, b4.in_ready, b4.busy} !== 3'b010) begin n_bad++; $display("FAIL rmid_run_ctrl: got %b want 010", {b4.out_valid, b4.in_ready, b4.busy}); end
        n_cmp++; if (b4.out_state !== 128'h0) begin n_bad++; $display("FAIL rmid_run_state: got %h want 0", b4.out_state); end
        seen = 1'b0;
        for (int i = 0; i < 8; i++) begin cyc(); if (b4.out_valid) seen = 1'b1; end
        n_cmp++; if (seen) begin n_bad++; $display("FAIL rmid_no_emit: got out_valid 1 want 0"); end
        // Reset coinciding with a DONE-state handshake
        accept4({$urandom(), $urandom(), $urandom(), $urandom()} | 128'h1, ok);
        wait_out4(20, lat, ok);
        rst = 1'b1;
        cyc();
        rst = 1'b0;
        exp_q.delete();
        n_cmp++; if (b4.out_state !== 128'h0 || {b4.out_valid, b4.in_ready, b4.busy} !== 3'b010) begin n_bad++; $display("FAIL rmid_done: got %h ctrl %b want 0 ctrl 010", b4.out_state, {b4.out_valid, b4.in_ready, b4.busy}); end
        accept4({16{8'h63}}, ok);
        wait_out4(20, lat, ok);
        n_cmp++; if (!ok || lat != 4) begin n_bad++; $display("FAIL rmid_after_lat: got %0d want 4", lat); end
        e = (exp_q.size() > 0) ? exp_q.pop_front() : 128'hx;
        n_cmp++; if (b4.out_state !== e) begin n_bad++; $display("FAIL rmid_after_data: got %h want %h", b4.out_state, e); end
        cyc();
    endtask

    task automatic test_exhaustive(input bit sel16);
        int w, lat, g; bit ok; logic [127:0] blk, e; logic [7:0] bt;
        ex_sel16 = sel16;
        ex_out_ready = 1'b1;
        g = sel16 ? 1 : 16;
        for (int k = 0; k < 16; k++) begin
            for (int i = 0; i < 16; i++) blk[127 - 8*i -: 8] = 8'(16*k + i);
            w = 0;
            while (!ex_in_ready && w < 40) begin cyc(); w++; end
            n_cmp++; if (ex_in_ready !== 1'b1) begin n_bad++; $display("FAIL ex%0d_ready%0d: got %b want 1", g, k, ex_in_ready); end
            ex_in_valid = 1'b1;
            ex_in_state = blk;
            exp_q.push_back(ref_block(blk));
            cyc();
            ex_in_valid = 1'b0;
            lat = 0; ok = 1'b0;
            while (lat < 40 && !ok) begin cyc(); lat++; ok = ex_out_valid; end
            n_cmp++; if (!ok || lat != g) begin n_bad++; $display("FAIL ex%0d_latency%0d: got %0d want %0d", g, k, lat, g); end
            e = (exp_q.size() > 0) ? exp_q.pop_front() : 128'hx;
            n_cmp++; if (ex_out_state !== e) begin n_bad++; $display("FAIL ex%0d_data%0d: got %h want %h", g, k, ex_out_state, e); end
            if (k == 0 || k == 5 || k == 7 || k == 15) begin
                case (k)
                    0:  begin bt = ex_out_state[127 -: 8];        e[7:0] = 8'h52; end
                    5:  begin bt = ex_out_state[127 - 16 -: 8];   e[7:0] = 8'h48; end
                    7:  begin bt = ex_out_state[127 - 96 -: 8];   e[7:0] = 8'h01; end
                    default: begin bt = ex_out_state[7:0];        e[7:0] = 8'h7d; end
                endcase
                n_cmp++; if (bt !== e[7:0]) begin n_bad++; $display("FAIL ex%0d_spot%0d: got %h want %h", g, k, bt, e[7:0]); end
            end
            cyc();
        end
    endtask

    initial begin
        rst = 1'b1;
        b4.in_valid = 1'b0; b4.in_state = '0; b4.out_ready = 1'b0;
        ex_sel16 = 1'b0; ex_in_valid = 1'b0; ex_in_state = '0; ex_out_ready = 1'b0;
        test_reset();
        test_single();
        test_back_to_back();
        test_backpressure();
        test_reset_mid();
        test_exhaustive(1'b0);
        test_exhaustive(1'b1);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not complete within time limit");
        $fatal(1, "watchdog expired");
    end
endmodule

// File: doc/inv_sub_bytes_iter.md
Name: inv_sub_bytes_iter

Overview:
Iterative InvSubBytes stage for the AES decryption datapath. It accepts one 128-bit state block and applies the AES inverse S-box to all 16 bytes, LANES bytes per cycle, using LANES combinational inverse S-box instances. The result goes to the next decryption stage over a valid/ready handshake. It sits between InvShiftRows and AddRoundKey and trades area against latency.

Parameters:
LANES, 4, bytes substituted per cycle. Legal values are 1, 2, 4, 8 and 16. Any other value is a synthesis error. G = 16/LANES is the number of group cycles.

Ports:
clk  input  1  rising-edge clock
rst  input  1  synchronous, active-high reset
in_valid  input  1  upstream offers in_state
in_ready  output  1  block can accept (high only in IDLE)
in_state  input  128  state block; byte 0 = in_state[127:120], byte 15 = in_state[7:0]
out_valid  output  1  out_state holds a completed result
out_ready  input  1  downstream accepts result
out_state  output  128  substituted block, same byte order
busy  output  1  high in RUN or DONE

Behaviour:
- All outputs and state are registered. Reset is sampled only at a clk posedge with rst=1. Reset values:
  - FSM=IDLE, grp=0
  - work register=0, so out_state=0
  - out_valid=0, busy=0, in_ready=1 (IDLE decode)
- FSM states are IDLE, RUN and DONE.
- IDLE:
  - in_ready=1.
  - On an edge with in_valid=1, capture in_state into the work register, set grp=0 and go to RUN.
  - in_valid=0 stays in IDLE.
- RUN:
  - in_ready=0, busy=1.
  - Each edge replaces bytes grp*LANES .. grp*LANES+LANES-1 of the work register with InvSBox(byte). Bytes are indexed from the MSB.
  - grp increments each edge. On the edge that processes grp=G-1, grp returns to 0 and the FSM goes to DONE.
- DONE:
  - out_valid=1, busy=1, in_ready=0.
  - out_state=work register, held bit-stable until the handshake.
  - On an edge with out_ready=1, the handshake completes and the FSM goes to IDLE with out_valid=0.
- out_state always reflects the work register. Its value is defined only while out_valid=1, except that it is 0 after reset.
- Latency:
  - The acceptance edge is edge 0. out_valid is high from edge G onward, e.g. 4 cycles for LANES=4 and 1 cycle for LANES=16.
  - With out_ready held high, the handshake occurs at edge G+1.
  - The earliest next acceptance is edge G+2, so the initiation interval is G+2.
- Boundary conditions:
  - in_valid during RUN or DONE is ignored. No capture occurs and no state is corrupted. Upstream must hold the block until in_ready=1.
  - out_ready held low stalls in DONE indefinitely with no data change.
  - out_ready asserted before out_valid has no effect.
  - Reset mid-RUN or mid-DONE aborts the block: next cycle the FSM is IDLE, out_valid=0, out_state=0, and no partial result is emitted.
  - rst=1 wins over any simultaneous handshake.
- Inverse S-box mapping is the standard AES inverse table, e.g. 00->52, 63->00, 7c->01, ff->7d.

Test Plan:
1. LANES=4, in_state=000102030405060708090a0b0c0d0e0f accepted at edge 0, out_ready=1 -> out_valid rises after edge 4; out_state=5209 6ad5 3036 a538 bf40 a39e 81f3 d7fb (hex); in_ready returns 1 after edge 5.
2. LANES=4, in_state all 0x63, then all 0x00 back-to-back -> first result all 0x00, second all 0x52; second acceptance no earlier than edge 6; in_valid held during busy causes no early capture.
3. Backpressure: after out_valid, hold out_ready=0 for 10 cycles while toggling in_valid/in_state -> out_state stable, in_ready=0, busy=1; release out_ready -> one transfer, then IDLE.
4. Reset mid-operation: assert rst at edge 2 of a LANES=4 block -> next cycle out_valid=0, out_state=0, in_ready=1, busy=0; a following block 63636363... yields all 0x00 correctly.
5. Exhaustive: LANES=1 and LANES=16 builds, 16 blocks covering bytes 00..ff -> every byte matches the inverse table (spot checks 00->52, 52->48, 7c->01, ff->7d); out_valid latency 16 and 1 cycles respectively.
